// File: rtl/cpu_pkg.sv
// Shared opcodes, result-select encoding and multiplier state type for the execute stage.
package cpu_pkg;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_HI  = 2'b01,
        SEL_LO  = 2'b10
    } lohi_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mult_hilo_unit_seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier, one multiplier bit per cycle, LSB first.
//   state | meaning
//   IDLE  | waiting for start, operands captured on start
//   RUN   | WIDTH add/shift steps
//   DONE  | product final for one cycle, done asserted
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, mcand_in};
                    mplier_d = mplier_in;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign product = acc_q;

endmodule

// File: rtl/mult_hilo_unit.sv
// MULT/MULTU execution with architectural HI/LO, the MFHI/MFLO result mux and pipeline stall.
module mult_hilo_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op_sel,
    input  logic             hi_en,
    input  logic             lo_en,
    input  logic [1:0]       alu_lo_hi,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    logic               is_mul_op, signed_op, mul_req, start;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] product, prod_signed;
    logic               mul_busy, mul_done;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   hi_d, lo_d;
    lohi_sel_t          sel;

    assign is_mul_op = (op_sel == OP_MULT) || (op_sel == OP_MULTU);
    assign signed_op = (op_sel == OP_MULT);
    assign mul_req   = hi_en && lo_en && is_mul_op;
    assign start     = mul_req && !mul_busy;

    // Magnitude stays WIDTH bits unsigned, so the most negative operand maps to 2^(WIDTH-1).
    assign mag_a = (signed_op && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b = (signed_op && in_b[WIDTH-1]) ? -in_b : in_b;

    seq_multiplier #(.WIDTH(WIDTH)) u_seq_multiplier (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mcand_in  (mag_a),
        .mplier_in (mag_b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (product)
    );

    always_comb begin
        sign_d      = sign_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        prod_signed = sign_q ? -product : product;
        if (start) begin
            sign_d = signed_op && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end
        if (mul_done) begin
            hi_d = prod_signed[2*WIDTH-1:WIDTH];
            lo_d = prod_signed[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            sign_q <= sign_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign sel = lohi_sel_t'(alu_lo_hi);

    always_comb begin
        case (sel)
            SEL_HI:  result_out = hi_q;
            SEL_LO:  result_out = lo_q;
            default: result_out = alu_result;
        endcase
    end

    assign busy  = mul_busy;
    assign done  = mul_done;
    assign stall = mul_busy && ((sel == SEL_HI) || (sel == SEL_LO) || mul_req);

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Randomized and directed bench for mult_hilo_unit against a cycle-count reference model.
module tb_mult_hilo_unit;
    import cpu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   op_sel = '0;
    logic         hi_en = 1'b0, lo_en = 1'b0;
    logic [1:0]   alu_lo_hi = '0;
    logic [W-1:0] in_a = '0, in_b = '0, alu_result = '0;
    logic [W-1:0] result_out, hi_q, lo_q;
    logic         busy, stall, done;

    mult_hilo_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_sel     (op_sel),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .alu_lo_hi  (alu_lo_hi),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_result (alu_result),
        .result_out (result_out),
        .hi_q       (hi_q),
        .lo_q       (lo_q),
        .busy       (busy),
        .stall      (stall),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == OP_MULT) return 64'(sa * sb);
        return 64'(ua * ub);
    endfunction

    function automatic bit is_req(input logic h, input logic l, input logic [5:0] op);
        return h && l && (op == OP_MULT || op == OP_MULTU);
    endfunction

    // Model: m_cnt counts remaining busy cycles; HI/LO land when the last one ends.
    int           m_cnt = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (m_cnt == 1) begin
            m_hi  <= p_hi;
            m_lo  <= p_lo;
            m_cnt <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else if (is_req(hi_en, lo_en, op_sel)) begin
            {p_hi, p_lo} <= ref_prod(op_sel, in_a, in_b);
            m_cnt        <= W + 1;
        end
    end

    logic [W-1:0] exp_res;
    logic         exp_busy, exp_stall, exp_done;

    always_comb begin
        exp_busy  = (m_cnt > 0);
        exp_done  = (m_cnt == 1);
        exp_stall = exp_busy && (alu_lo_hi == 2'b01 || alu_lo_hi == 2'b10 ||
                                 is_req(hi_en, lo_en, op_sel));
        case (alu_lo_hi)
            2'b01:   exp_res = m_hi;
            2'b10:   exp_res = m_lo;
            default: exp_res = alu_result;
        endcase
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("done", 32'(done), 32'(exp_done));
            chk("hi_q", hi_q, m_hi);
            chk("lo_q", lo_q, m_lo);
            chk("result_out", result_out, exp_res);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        op_sel = op;
        in_a   = a;
        in_b   = b;
        hi_en  = 1'b1;
        lo_en  = 1'b1;
    endtask

    task automatic idle_ctl();
        hi_en  = 1'b0;
        lo_en  = 1'b0;
        op_sel = 6'd0;
    endtask

    // Counts negedges until done is seen; a missing pulse is reported as a failed check.
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 60);
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, lat);
        end
    endtask

    task automatic run_mul(input string name, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, output int lat);
        issue(op, a, b);
        step();
        idle_ctl();
        wait_done(name, lat);
        step();
    endtask

    logic [63:0]  pin;
    logic [W-1:0] saved_hi, saved_lo;
    int           lat, n_stall;
    int           r;

    initial begin
        #1;
        checking = 1'b1;

        pin = ref_prod(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pin_multu_hi", pin[63:32], 32'hFFFF_FFFE);
        chk("pin_multu_lo", pin[31:0], 32'h0000_0001);
        pin = ref_prod(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("pin_mult_neg_lo", pin[31:0], 32'hFFFF_FFF1);
        pin = ref_prod(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        chk("pin_mult_corner_hi", pin[63:32], 32'h4000_0000);

        repeat (3) step();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi_q, 32'd0);
        chk("reset_lo", lo_q, 32'd0);
        rst_n = 1'b1;
        step();

        run_mul("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_ff_latency", 32'(lat), 32'd33);
        chk("multu_ff_hi", hi_q, 32'hFFFF_FFFE);
        chk("multu_ff_lo", lo_q, 32'h0000_0001);

        run_mul("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, lat);
        chk("mult_neg_hi", hi_q, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo_q, 32'hFFFF_FFF1);

        run_mul("mult_corner", OP_MULT, 32'h8000_0000, 32'h8000_0000, lat);
        chk("mult_corner_hi", hi_q, 32'h4000_0000);
        chk("mult_corner_lo", lo_q, 32'h0000_0000);

        issue(OP_MULT, 32'd7, 32'd6);
        step();
        idle_ctl();
        alu_lo_hi = 2'b10;
        n_stall = 0;
        do begin
            @(negedge clk);
            if (stall) n_stall++;
        end while (stall && n_stall < 60);
        chk("mflo_after_stall", result_out, 32'h0000_002A);
        step();
        alu_lo_hi = 2'b01;
        #1;
        chk("mfhi_after_mult", result_out, 32'h0000_0000);

        saved_hi = hi_q;
        saved_lo = lo_q;
        step();
        issue(6'b100001, 32'd11, 32'd22);
        alu_lo_hi  = 2'b00;
        alu_result = 32'h1234_5678;
        #1;
        chk("addu_pass", result_out, 32'h1234_5678);
        step();
        chk("addu_no_busy", 32'(busy), 32'd0);
        chk("addu_hi_kept", hi_q, saved_hi);
        chk("addu_lo_kept", lo_q, saved_lo);
        idle_ctl();
        step();

        issue(OP_MULT, 32'd100, 32'hFFFF_FFFE);
        step();
        issue(OP_MULT, 32'hFFFF_FFF9, 32'd9);
        wait_done("second_first", lat);
        chk("second_stall_at_done", 32'(stall), 32'd1);
        step();
        chk("second_first_hi", hi_q, 32'hFFFF_FFFF);
        chk("second_first_lo", lo_q, 32'hFFFF_FF38);
        step();
        idle_ctl();
        wait_done("second_reissue", lat);
        chk("second_reissue_latency", 32'(lat), 32'd33);
        step();
        chk("second_reissue_hi", hi_q, 32'hFFFF_FFFF);
        chk("second_reissue_lo", lo_q, 32'hFFFF_FFC1);

        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        step();
        idle_ctl();
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi_q, 32'd0);
        chk("abort_lo", lo_q, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        run_mul("fresh_multu", OP_MULTU, 32'd2, 32'd3, lat);
        chk("fresh_lo", lo_q, 32'd6);
        chk("fresh_hi", hi_q, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            step();
            rst_n = ($urandom_range(0, 299) != 0);
            r = $urandom_range(0, 3);
            if (r == 0)      op_sel = OP_MULT;
            else if (r == 1) op_sel = OP_MULTU;
            else             op_sel = 6'($urandom_range(0, 63));
            hi_en      = ($urandom_range(0, 3) != 0);
            lo_en      = ($urandom_range(0, 3) != 0);
            alu_lo_hi  = 2'($urandom_range(0, 3));
            alu_result = $urandom;
            case ($urandom_range(0, 5))
                0:       in_a = 32'h8000_0000;
                1:       in_a = 32'hFFFF_FFFF;
                2:       in_a = 32'($urandom_range(0, 15));
                default: in_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       in_b = 32'h8000_0000;
                1:       in_b = 32'hFFFF_FFFF;
                2:       in_b = 32'($urandom_range(0, 15));
                default: in_b = $urandom;
            endcase
        end
        rst_n = 1'b1;
        idle_ctl();
        repeat (40) step();

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
